// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 2^DEPTH_LOG2 x WIDTH word store for the core RAM port
// Clears every word after reset, then serves one-cycle synchronous reads plus a valid/ready preload port.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wren,
  output logic [WIDTH-1:0]      q,
  input  logic                  ld_valid,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_data,
  output logic                  ld_ready,
  output logic                  init_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   clr_cnt;
  logic [WIDTH-1:0]        mem [DEPTH];

  logic                    we;
  logic [DEPTH_LOG2-1:0]   waddr;
  logic [WIDTH-1:0]        wdata;

  // Core write has priority; a pending load simply waits for a cycle without one.
  assign ld_ready = (state == SERVE) && ld_valid && !wren;

  always_comb begin
    we    = 1'b0;
    waddr = clr_cnt;
    wdata = '0;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (wren) begin
      we    = 1'b1;
      waddr = addr;
      wdata = data;
    end else if (ld_ready) begin
      we    = 1'b1;
      waddr = ld_addr;
      wdata = ld_data;
    end
  end

  // Array has no reset; the clear sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      q         <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          q       <= '0;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {DEPTH_LOG2{1'b1}}) begin
            state     <= SERVE;
            init_done <= 1'b1;
          end
        end
        SERVE: begin
          q <= mem[addr];
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
